// File: rtl/ex_div.sv
// Multi-cycle restoring divider for DIV/DIVU in the execute stage.
// One quotient bit per clock; result is {remainder, quotient}.
module ex_div #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            signed_div_i,
    input  logic [DW-1:0]   opdata1_i,
    input  logic [DW-1:0]   opdata2_i,
    input  logic            start_i,
    input  logic            annul_i,
    output logic [2*DW-1:0] result_o,
    output logic            ready_o
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t state_q, state_d;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [DW-1:0]   dvs_q, dvs_d;
    logic            sgn_q, sgn_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic [2*DW-1:0] result_d;
    logic            ready_d;

    logic            go;
    logic            last;
    logic            neg_a;
    logic            neg_b;
    logic [DW-1:0]   mag_a;
    logic [DW-1:0]   mag_b;
    logic [DW:0]     shifted;
    logic [DW+1:0]   trial;
    logic            keep;
    logic [DW-1:0]   quo_fix;
    logic [DW-1:0]   rem_fix;

    assign go    = start_i && !annul_i;
    assign last  = (cnt_q == CW'(DW));
    assign neg_a = signed_div_i && opdata1_i[DW-1];
    assign neg_b = signed_div_i && opdata2_i[DW-1];
    assign mag_a = neg_a ? -opdata1_i : opdata1_i;
    assign mag_b = neg_b ? -opdata2_i : opdata2_i;

    // The remainder is always below the divisor, so the shifted
    // partial remainder fits DW+1 bits and the kept difference fits DW.
    assign shifted = {rem_q, quo_q[DW-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dvs_q};
    assign keep    = !trial[DW+1];

    assign quo_fix = (sgn_q && (neg_a_q ^ neg_b_q)) ? -quo_q : quo_q;
    assign rem_fix = (sgn_q && neg_a_q) ? -rem_q : rem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= FREE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FREE: begin
                if (go) state_d = (|opdata2_i) ? ON : BYZERO;
            end
            BYZERO: state_d = END;
            ON: begin
                if (annul_i)   state_d = FREE;
                else if (last) state_d = END;
            end
            END: begin
                if (!start_i) state_d = FREE;
            end
            default: state_d = FREE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        sgn_d    = sgn_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_o;
        ready_d  = ready_o;
        unique case (state_q)
            FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (go && |opdata2_i) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = mag_a;
                    dvs_d   = mag_b;
                    sgn_d   = signed_div_i;
                    neg_a_d = neg_a;
                    neg_b_d = neg_b;
                end
            end
            BYZERO: begin
                result_d = '0;
                ready_d  = 1'b1;
            end
            ON: begin
                if (annul_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (last) begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end else begin
                    rem_d = keep ? trial[DW-1:0] : shifted[DW-1:0];
                    quo_d = {quo_q[DW-2:0], keep};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            END: begin
                if (!start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sgn_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sgn_q    <= sgn_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: stimulus queues expected results,
// a negedge monitor checks each ready rise for value and latency.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    typedef struct {
        logic [63:0] res;
        int          edge_no;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   edge_n = 0;
    logic prev_rdy = 1'b0;

    ex_div #(.DW(32)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every rising ready must match the oldest queued result.
    always @(negedge clk) begin
        exp_t e;
        if (ready && !prev_rdy) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready actual=%h required=none",
                         result);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("latency", 64'(edge_n), 64'(e.edge_no));
            end
        end
        prev_rdy = ready;
    end

    task automatic do_op(input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input bit toggle, input bit rst_in_end);
        int e1;
        int n;
        exp_t e;
        @(negedge clk);
        signed_div = sg;
        op1 = a;
        op2 = b;
        start = 1'b1;
        e1 = edge_n + 1;
        e.res = exp;
        e.edge_no = e1 + ((b == 0) ? 1 : 33);
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (toggle) begin
                op1 = $urandom;
                op2 = $urandom;
                signed_div = ~signed_div;
            end
        end while (!ready && n < 60);
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1");
            sb.delete();
            start = 1'b0;
            return;
        end
        repeat (2) @(negedge clk);
        chk("hold_ready", 64'(ready), 64'd1);
        chk("hold_result", result, exp);
        if (rst_in_end) begin
            #2 rst_n = 1'b0;
            #1;
            chk("async_rst_ready", 64'(ready), 64'd0);
            chk("async_rst_result", result, 64'd0);
            start = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("release_ready", 64'(ready), 64'd0);
        chk("release_result", result, 64'd0);
    endtask

    task automatic watch_idle(input string nm, input int cycles);
        int hi;
        hi = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (ready) hi++;
        end
        chk(nm, 64'(hi), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_idle("idle_no_ready", 3);

        do_op(1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 1'b0, 1'b0);
        do_op(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b0);
        do_op(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 1'b0);
        do_op(1'b0, 32'd5, 32'd0, 64'h0, 1'b0, 1'b0);
        do_op(1'b1, 32'hFFFFFFF9, 32'd0, 64'h0, 1'b0, 1'b0);
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b0);
        do_op(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 1'b0, 1'b0);
        do_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 1'b0, 1'b0);
        do_op(1'b0, 32'd1000, 32'd7, 64'h00000006_0000008E, 1'b1, 1'b0);
        do_op(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b1, 1'b0);

        // Annul at iteration 10.
        @(negedge clk);
        signed_div = 1'b0;
        op1 = 32'd1000;
        op2 = 32'd3;
        start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        watch_idle("annul_no_ready", 40);
        do_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 1'b0);

        // Async reset at iteration 20, between edges.
        @(negedge clk);
        op1 = 32'd50;
        op2 = 32'd5;
        start = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midop_rst_ready", 64'(ready), 64'd0);
        chk("midop_rst_result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        watch_idle("midop_rst_no_ready", 40);

        do_op(1'b0, 32'd20, 32'd6, 64'h00000002_00000003, 1'b0, 1'b1);
        do_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
